// File: rtl/spi_frame_shifter_pkg.sv
// Shared definitions for the SPI frame shifter: FSM encoding, default sizing
// and the SPI clocking mode the shifter is built for.
package spi_frame_shifter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_COUNTWIDTH = 4;

    // {CPOL, CPHA}; mode 0 samples on the SCLK rise and shifts on the fall.
    localparam logic [1:0] SPI_MODE = 2'b00;

endpackage

// File: rtl/frame_shiftreg.sv
// Width-parameterised MSB-first shift register used both as the receive SIPO
// and the transmit PISO. A parallel load wins over a shift in the same cycle.
module frame_shiftreg #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [width-1:0] load_value,
    output logic [width-1:0] parallel_out,
    output logic             msb_out
);

    logic [width-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= load_value;
        end else if (shift_en) begin
            data_q <= {data_q[width-2:0], serial_in};
        end
    end

    assign parallel_out = data_q;
    assign msb_out      = data_q[width-1];

endmodule

// File: rtl/spi_frame_shifter.sv
// SPI slave frame engine: deserialises MOSI into frames and serialises a held
// transmit word onto MISO, driven by pre-conditioned CS and SCLK edge pulses.
module spi_frame_shifter
    import spi_frame_shifter_pkg::*;
#(
    parameter int width      = DEFAULT_WIDTH,
    parameter int countwidth = DEFAULT_COUNTWIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs_cond,
    input  logic                  mosi_cond,
    input  logic                  sclk_posedge,
    input  logic                  sclk_negedge,
    input  logic [width-1:0]      tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  miso_out,
    output logic                  miso_oe,
    output logic [width-1:0]      rx_data,
    output logic                  rx_valid,
    output logic [countwidth-1:0] bit_count,
    output logic                  frame_err,
    output state_e                state
);

    localparam logic [countwidth-1:0] last_bit = countwidth'(width - 1);
    // Modes 0 and 3 sample on the rising SCLK edge; 1 and 2 on the falling.
    localparam bit sample_on_rise = (SPI_MODE[0] == SPI_MODE[1]);

    state_e state_q;
    state_e state_d;

    logic             sample_pulse;
    logic             shift_pulse;
    logic             edges_live;
    logic             rx_sample;
    logic             tx_step;
    logic             frame_last;
    logic             abort;
    logic             idle_reload;
    logic             boundary_step;
    logic             tx_load_en;
    logic [width-1:0] tx_load_value;
    logic             tx_shift_en;

    logic [width-1:0] tx_hold;
    logic             tx_hold_valid;
    logic [width-1:0] rx_par;
    logic             rx_msb;
    logic [width-1:0] tx_par;
    logic             tx_msb;
    logic             unused_taps;

    assign sample_pulse = sample_on_rise ? sclk_posedge : sclk_negedge;
    assign shift_pulse  = sample_on_rise ? sclk_negedge : sclk_posedge;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_cond) state_d = ACTIVE;
            ACTIVE:  if (cs_cond)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs and per-cycle action decode
    always_comb begin
        miso_oe       = 1'b0;
        edges_live    = 1'b0;
        abort         = 1'b0;
        idle_reload   = 1'b0;
        case (state_q)
            IDLE: begin
                idle_reload = tx_hold_valid;
            end
            ACTIVE: begin
                miso_oe    = 1'b1;
                edges_live = !cs_cond;
                abort      = cs_cond && (bit_count != '0);
            end
            default: ;
        endcase
    end

    // A sample edge coinciding with a shift edge wins; the shift is dropped.
    assign rx_sample     = edges_live && sample_pulse;
    assign tx_step       = edges_live && shift_pulse && !sample_pulse;
    assign frame_last    = rx_sample && (bit_count == last_bit);
    assign boundary_step = tx_step && (bit_count == '0);

    // Transmit path: reload at IDLE or frame boundary, clear on abort.
    assign tx_load_en    = idle_reload || boundary_step || abort;
    assign tx_load_value = (abort || !tx_hold_valid) ? '0 : tx_hold;
    assign tx_shift_en   = tx_step && (bit_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold       <= '0;
            tx_hold_valid <= 1'b0;
        end else if (tx_load && !tx_hold_valid) begin
            tx_hold       <= tx_data;
            tx_hold_valid <= 1'b1;
        end else if (idle_reload || boundary_step) begin
            tx_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_count <= '0;
        end else if ((state_q == IDLE) && !cs_cond) begin
            bit_count <= '0;
        end else if (abort) begin
            bit_count <= '0;
        end else if (rx_sample) begin
            bit_count <= frame_last ? '0 : bit_count + countwidth'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= frame_last;
            frame_err <= abort;
            if (frame_last) begin
                rx_data <= {rx_par[width-2:0], mosi_cond};
            end
        end
    end

    frame_shiftreg #(.width(width)) u_rx_shift (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (mosi_cond),
        .shift_en     (rx_sample),
        .load_en      (abort),
        .load_value   ('0),
        .parallel_out (rx_par),
        .msb_out      (rx_msb)
    );

    frame_shiftreg #(.width(width)) u_tx_shift (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (1'b0),
        .shift_en     (tx_shift_en),
        .load_en      (tx_load_en),
        .load_value   (tx_load_value),
        .parallel_out (tx_par),
        .msb_out      (tx_msb)
    );

    assign unused_taps = ^{rx_msb, tx_par};

    assign tx_ready = !tx_hold_valid;
    assign miso_out = tx_msb;
    assign state    = state_q;

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Self-checking bench for spi_frame_shifter: scenario tasks plus an rx_data
// scoreboard fed with expected frames and drained on every rx_valid.
module tb_spi_frame_shifter;
    import spi_frame_shifter_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs_cond;
    logic          mosi_cond;
    logic          sclk_posedge;
    logic          sclk_negedge;
    logic [W-1:0]  tx_data;
    logic          tx_load;
    logic          tx_ready;
    logic          miso_out;
    logic          miso_oe;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [CW-1:0] bit_count;
    logic          frame_err;
    state_e        state;

    int tests_run    = 0;
    int tests_failed = 0;
    int rx_count     = 0;
    int err_count    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] last_rx;

    spi_frame_shifter #(.width(W), .countwidth(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cs_cond      (cs_cond),
        .mosi_cond    (mosi_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_ready     (tx_ready),
        .miso_out     (miso_out),
        .miso_oe      (miso_oe),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .bit_count    (bit_count),
        .frame_err    (frame_err),
        .state        (state)
    );

    // Clock and run-time bound
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Scoreboard: every rx_valid pops one expected frame
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            rx_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no frame", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rx_data !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL rx_frame: rx_data=%h, required %h", rx_data, mon_exp);
                end
            end
        end
        if (reset_n && frame_err) err_count++;
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pos_pulse(input logic b, input logic both, output logic m);
        m            = miso_out;
        mosi_cond    = b;
        sclk_posedge = 1'b1;
        sclk_negedge = both;
        cycle();
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
    endtask

    task automatic neg_pulse();
        sclk_negedge = 1'b1;
        cycle();
        sclk_negedge = 1'b0;
        cycle();
    endtask

    task automatic preload(input logic [W-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        cycle();
        tx_load = 1'b0;
        cycle();
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0; cs_cond = 1'b1; mosi_cond = 1'b0;
        sclk_posedge = 1'b0; sclk_negedge = 1'b0; tx_data = '0; tx_load = 1'b0;
        cycle(); cycle();
        tests_run++;
        if ({tx_ready, miso_out, miso_oe, rx_valid, frame_err} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_flags: {ready,miso,oe,valid,err}=%b, required 10000",
                     {tx_ready, miso_out, miso_oe, rx_valid, frame_err});
        end
        tests_run++;
        if (rx_data !== '0 || bit_count !== '0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_regs: rx_data=%h bit_count=%0d state=%0d, required 0/0/IDLE",
                     rx_data, bit_count, state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        last_rx = '0;
    endtask

    task automatic test_basic();
        logic [W-1:0] tx_pat = 8'hA5;
        logic [W-1:0] rx_pat = 8'h3C;
        logic m;
        int rc;
        tx_data = tx_pat; tx_load = 1'b1;
        cycle();
        tx_load = 1'b0;
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ready_low: tx_ready=%b, required 0", tx_ready);
        end
        cycle();
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready_back: tx_ready=%b, required 1", tx_ready);
        end
        cs_cond = 1'b0;
        cycle();
        tests_run++;
        if (miso_oe !== 1'b1 || state !== ACTIVE) begin
            tests_failed++;
            $display("FAIL basic_active: miso_oe=%b state=%0d, required 1/ACTIVE", miso_oe, state);
        end
        rc = rx_count;
        exp_q.push_back(rx_pat);
        for (int i = W - 1; i >= 0; i--) begin
            pos_pulse(rx_pat[i], 1'b0, m);
            tests_run++;
            if (m !== tx_pat[i]) begin
                tests_failed++;
                $display("FAIL basic_miso bit %0d: miso=%b, required %b", i, m, tx_pat[i]);
            end
            if (i == 0) begin
                tests_run++;
                if (rx_valid !== 1'b1 || rx_data !== rx_pat) begin
                    tests_failed++;
                    $display("FAIL basic_rx_latency: rx_valid=%b rx_data=%h, required 1/%h",
                             rx_valid, rx_data, rx_pat);
                end
            end
            neg_pulse();
        end
        cs_cond = 1'b1;
        cycle(); cycle();
        tests_run++;
        if (rx_count !== rc + 1) begin
            tests_failed++;
            $display("FAIL basic_rx_once: rx_valid pulses=%0d, required 1", rx_count - rc);
        end
        last_rx = rx_pat;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx_bits;
        logic [15:0] exp_miso = 16'hA55A;
        logic [W-1:0] rx1, rx2;
        logic m;
        int rc;
        rx1 = W'($urandom_range(0, 255));
        rx2 = W'($urandom_range(0, 255));
        rx_bits = {rx1, rx2};
        preload(8'hA5);
        cs_cond = 1'b0;
        cycle();
        rc = rx_count;
        exp_q.push_back(rx1);
        exp_q.push_back(rx2);
        for (int k = 0; k < 16; k++) begin
            pos_pulse(rx_bits[15-k], 1'b0, m);
            tests_run++;
            if (m !== exp_miso[15-k]) begin
                tests_failed++;
                $display("FAIL b2b_miso bit %0d: miso=%b, required %b", k, m, exp_miso[15-k]);
            end
            if (k == 2 || k == 4) begin
                tx_data = (k == 2) ? 8'h5A : 8'hFF;
                tx_load = 1'b1;
                cycle();
                tx_load = 1'b0;
                tests_run++;
                if (tx_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_hold_full step %0d: tx_ready=%b, required 0", k, tx_ready);
                end
            end
            neg_pulse();
            if (k == 7) begin
                tests_run++;
                if (tx_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_boundary_reload: tx_ready=%b, required 1", tx_ready);
                end
            end
        end
        cs_cond = 1'b1;
        cycle(); cycle();
        tests_run++;
        if (rx_count !== rc + 2) begin
            tests_failed++;
            $display("FAIL b2b_rx_count: rx_valid pulses=%0d, required 2", rx_count - rc);
        end
        last_rx = rx2;
    endtask

    task automatic test_abort_mid();
        logic m;
        int rc, ec;
        cs_cond = 1'b0;
        cycle();
        rc = rx_count;
        ec = err_count;
        for (int i = 0; i < 5; i++) begin
            pos_pulse(1'($urandom_range(0, 1)), 1'b0, m);
            neg_pulse();
        end
        cs_cond = 1'b1;
        cycle();
        tests_run++;
        if (frame_err !== 1'b1 || bit_count !== '0) begin
            tests_failed++;
            $display("FAIL abort_mid_err: frame_err=%b bit_count=%0d, required 1/0", frame_err, bit_count);
        end
        cycle();
        tests_run++;
        if (frame_err !== 1'b0 || err_count !== ec + 1) begin
            tests_failed++;
            $display("FAIL abort_mid_pulse: frame_err=%b pulses=%0d, required 0/1", frame_err, err_count - ec);
        end
        tests_run++;
        if (rx_data !== last_rx || rx_count !== rc) begin
            tests_failed++;
            $display("FAIL abort_mid_rx: rx_data=%h rx_valid pulses=%0d, required %h/0",
                     rx_data, rx_count - rc, last_rx);
        end
    endtask

    task automatic test_abort_final();
        logic m;
        int rc;
        cs_cond = 1'b0;
        cycle();
        rc = rx_count;
        for (int i = 0; i < W - 1; i++) begin
            pos_pulse(1'($urandom_range(0, 1)), 1'b0, m);
            neg_pulse();
        end
        cs_cond = 1'b1;
        pos_pulse(1'b1, 1'b0, m);
        tests_run++;
        if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_final: frame_err=%b rx_valid=%b, required 1/0", frame_err, rx_valid);
        end
        cycle();
        tests_run++;
        if (rx_count !== rc || rx_data !== last_rx) begin
            tests_failed++;
            $display("FAIL abort_final_rx: rx_valid pulses=%0d rx_data=%h, required 0/%h",
                     rx_count - rc, rx_data, last_rx);
        end
    endtask

    task automatic test_ignored_edges();
        logic [W-1:0] tx_pat = 8'hC3;
        logic [W-1:0] rxb;
        logic m;
        int rc;
        for (int i = 0; i < 4; i++) begin
            pos_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m);
            neg_pulse();
        end
        tests_run++;
        if (bit_count !== '0 || miso_oe !== 1'b0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL idle_edges: bit_count=%0d miso_oe=%b state=%0d, required 0/0/IDLE",
                     bit_count, miso_oe, state);
        end
        rxb = W'($urandom_range(0, 255));
        preload(tx_pat);
        cs_cond = 1'b0;
        cycle();
        rc = rx_count;
        exp_q.push_back(rxb);
        for (int i = W - 1; i >= 0; i--) begin
            pos_pulse(rxb[i], (i == W - 2), m);
            tests_run++;
            if (m !== tx_pat[i]) begin
                tests_failed++;
                $display("FAIL simul_edges_miso bit %0d: miso=%b, required %b", i, m, tx_pat[i]);
            end
            neg_pulse();
        end
        cs_cond = 1'b1;
        cycle(); cycle();
        tests_run++;
        if (rx_count !== rc + 1) begin
            tests_failed++;
            $display("FAIL simul_edges_rx: rx_valid pulses=%0d, required 1", rx_count - rc);
        end
        last_rx = rxb;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] tx_pat = 8'h96;
        logic [W-1:0] rxb;
        logic m;
        int ec, rc;
        preload(8'hFF);
        cs_cond = 1'b0;
        cycle();
        ec = err_count;
        for (int i = 0; i < 3; i++) begin
            pos_pulse(1'b1, 1'b0, m);
            neg_pulse();
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({tx_ready, miso_out, miso_oe, rx_valid, frame_err} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL async_reset_flags: {ready,miso,oe,valid,err}=%b, required 10000",
                     {tx_ready, miso_out, miso_oe, rx_valid, frame_err});
        end
        tests_run++;
        if (rx_data !== '0 || bit_count !== '0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL async_reset_regs: rx_data=%h bit_count=%0d state=%0d, required 0/0/IDLE",
                     rx_data, bit_count, state);
        end
        cs_cond = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        tests_run++;
        if (err_count !== ec) begin
            tests_failed++;
            $display("FAIL async_reset_no_err: frame_err pulses=%0d, required 0", err_count - ec);
        end
        rxb = W'($urandom_range(0, 255));
        preload(tx_pat);
        cs_cond = 1'b0;
        cycle();
        rc = rx_count;
        exp_q.push_back(rxb);
        for (int i = W - 1; i >= 0; i--) begin
            pos_pulse(rxb[i], 1'b0, m);
            tests_run++;
            if (m !== tx_pat[i]) begin
                tests_failed++;
                $display("FAIL post_reset_miso bit %0d: miso=%b, required %b", i, m, tx_pat[i]);
            end
            neg_pulse();
        end
        cs_cond = 1'b1;
        cycle(); cycle();
        tests_run++;
        if (rx_count !== rc + 1) begin
            tests_failed++;
            $display("FAIL post_reset_rx: rx_valid pulses=%0d, required 1", rx_count - rc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort_mid();
        test_abort_final();
        test_ignored_edges();
        test_async_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
